seven_segment_capture: RTL and testbench

Receive-side counterpart of the two-digit multiplexed 7-segment display controller. It samples an externally driven, time-multiplexed 2-anode / 7-cathode bus and demultiplexes it into per-digit segment registers. It debounces each multiplex phase and decodes captured glyphs to hex nibbles, so the design can read back what another board or front panel is showing.

---
 rtl/seven_segment_capture.sv | 120 ++++++++++++
 tb/tb_seven_segment_capture.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: samples a multiplexed 2-anode/7-cathode bus, debounces each phase and demuxes it into per-digit registers.
// Define SEVEN_SEGMENT_CAPTURE_HEX_DECODE_EN to build the glyph-to-nibble decode (hex_x/is_hex_x); otherwise those outputs are 0.
module seven_segment_capture #(
   parameter int STABLE_CYCLES  = 64,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic [1:0] i_anode_in,
   input  logic [6:0] i_segments_in,
   output logic [6:0] o_seg_1,
   output logic [6:0] o_seg_2,
   output logic [3:0] o_hex_1,
   output logic [3:0] o_hex_2,
   output logic       o_is_hex_1,
   output logic       o_is_hex_2,
   output logic       o_valid_1,
   output logic       o_valid_2,
   output logic       o_update,
   output logic       o_update_sel
);
   localparam logic [1:0]  IDLE        = 2'd0;
   localparam logic [1:0]  SETTLE      = 2'd1;
   localparam logic [1:0]  HELD        = 2'd2;
   localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 2);
   localparam logic [23:0] TO_LAST     = 24'(TIMEOUT_CYCLES - 1);
   logic [8:0]  r_sync1, r_sync2, r_prev;
   logic [15:0] r_cnt;
   logic [1:0]  r_state;
   logic        r_update, r_update_sel;
   logic        w_chg, w_anode_ok, w_capture;
   assign w_chg      = r_sync2 != r_prev;
   assign w_anode_ok = r_sync2[8] ^ r_sync2[7];
   // Capture fires on the edge where the counter reaches STABLE_CYCLES-1.
   assign w_capture  = r_state == SETTLE && !w_chg && r_cnt == STABLE_LAST;
`ifdef SEVEN_SEGMENT_CAPTURE_HEX_DECODE_EN
   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'h01:   decode = 5'h10;
         7'h4F:   decode = 5'h11;
         7'h12:   decode = 5'h12;
         7'h06:   decode = 5'h13;
         7'h4C:   decode = 5'h14;
         7'h24:   decode = 5'h15;
         7'h20:   decode = 5'h16;
         7'h0F:   decode = 5'h17;
         7'h00:   decode = 5'h18;
         7'h04:   decode = 5'h19;
         7'h08:   decode = 5'h1A;
         7'h60:   decode = 5'h1B;
         7'h31:   decode = 5'h1C;
         7'h42:   decode = 5'h1D;
         7'h30:   decode = 5'h1E;
         7'h38:   decode = 5'h1F;
         default: decode = 5'h00;
      endcase
   endfunction
`endif
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_sync1      <= '0;
         r_sync2      <= '0;
         r_prev       <= '0;
         r_cnt        <= '0;
         r_state      <= IDLE;
         r_update     <= 1'b0;
         r_update_sel <= 1'b0;
      end else begin
         r_sync1      <= {i_anode_in, i_segments_in};
         r_sync2      <= r_sync1;
         r_prev       <= r_sync2;
         r_cnt        <= w_chg ? 16'd0 : (r_cnt == 16'hFFFF ? r_cnt : r_cnt + 16'd1);
         r_state      <= w_chg ? (w_anode_ok ? SETTLE : IDLE) : (w_capture ? HELD : r_state);
         r_update     <= w_capture;
         r_update_sel <= w_capture ? r_sync2[8] : r_update_sel;
      end
   end
   for (genvar g = 0; g < 2; g++) begin : g_dig
      logic [6:0]  r_seg;
      logic        r_valid;
      logic [23:0] r_to;
      logic        w_cap, w_exp;
      assign w_cap = w_capture && r_sync2[8:7] == 2'(g + 1);
      assign w_exp = r_to == TO_LAST;
      always_ff @(posedge i_clock) begin
         r_to <= (i_reset || w_cap) ? 24'd0 : (r_to == 24'hFFFFFF ? r_to : r_to + 24'd1);
         if (i_reset || (w_exp && !w_cap)) begin
            r_seg   <= 7'h7F;
            r_valid <= 1'b0;
         end else if (w_cap) begin
            r_seg   <= r_sync2[6:0];
            r_valid <= 1'b1;
         end
      end
`ifdef SEVEN_SEGMENT_CAPTURE_HEX_DECODE_EN
      logic [4:0] r_dec;
      always_ff @(posedge i_clock) begin
         if (i_reset || (w_exp && !w_cap)) r_dec <= 5'h00;
         else if (w_cap) r_dec <= decode(r_sync2[6:0]);
      end
`endif
   end
   assign o_seg_1      = g_dig[0].r_seg;
   assign o_seg_2      = g_dig[1].r_seg;
   assign o_valid_1    = g_dig[0].r_valid;
   assign o_valid_2    = g_dig[1].r_valid;
   assign o_update     = r_update;
   assign o_update_sel = r_update_sel;
`ifdef SEVEN_SEGMENT_CAPTURE_HEX_DECODE_EN
   assign o_hex_1    = g_dig[0].r_dec[3:0];
   assign o_hex_2    = g_dig[1].r_dec[3:0];
   assign o_is_hex_1 = g_dig[0].r_dec[4];
   assign o_is_hex_2 = g_dig[1].r_dec[4];
`else
   assign o_hex_1    = 4'h0;
   assign o_hex_2    = 4'h0;
   assign o_is_hex_1 = 1'b0;
   assign o_is_hex_2 = 1'b0;
`endif
endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture: randomized phases against a run-length reference model, checked by a scoreboard monitor on update pulses.
module tb_seven_segment_capture;
   localparam int S = 64;
   localparam int T = 1000;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] an  = 2'b00;
   logic [6:0] sg  = 7'h00;
   logic [6:0] seg_1, seg_2;
   logic [3:0] hex_1, hex_2;
   logic       is_hex_1, is_hex_2, valid_1, valid_2, update, update_sel;
   seven_segment_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .i_clock(clk), .i_reset(rst), .i_anode_in(an), .i_segments_in(sg),
      .o_seg_1(seg_1), .o_seg_2(seg_2), .o_hex_1(hex_1), .o_hex_2(hex_2),
      .o_is_hex_1(is_hex_1), .o_is_hex_2(is_hex_2), .o_valid_1(valid_1), .o_valid_2(valid_2),
      .o_update(update), .o_update_sel(update_sel)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int n_cmp = 0;
   int n_fail = 0;
   typedef struct {int t; logic sel; logic [6:0] seg;} exp_t;
   typedef struct {logic [1:0] an; logic [6:0] sg; int len;} ph_t;
   exp_t sbq[$];
   ph_t  seq[$];
   logic [6:0] glyph [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
   function automatic logic [4:0] ref_dec(input logic [6:0] p);
      ref_dec = 5'h00;
`ifdef SEVEN_SEGMENT_CAPTURE_HEX_DECODE_EN
      for (int i = 0; i < 16; i++) if (glyph[i] == p) ref_dec = {1'b1, 4'(i)};
`endif
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   always @(negedge clk) begin : mon
      exp_t e;
      logic [4:0] d;
      if (update === 1'b1) begin
         if (sbq.size() == 0) check("spurious_update", update, 0);
         else begin
            e = sbq.pop_front();
            d = ref_dec(e.seg);
            check("update_time", cyc, e.t);
            check("update_sel", update_sel, e.sel);
            if (!e.sel) begin
               check("cap_seg_1", seg_1, e.seg);
               check("cap_hex_1", hex_1, d[3:0]);
               check("cap_is_hex_1", is_hex_1, d[4]);
               check("cap_valid_1", valid_1, 1);
            end else begin
               check("cap_seg_2", seg_2, e.seg);
               check("cap_hex_2", hex_2, d[3:0]);
               check("cap_is_hex_2", is_hex_2, d[4]);
               check("cap_valid_2", valid_2, 1);
            end
         end
      end
   end
   task automatic finalize(input logic [8:0] v, input int start, input int len);
      if ((v[8] ^ v[7]) && len >= S + 2) sbq.push_back('{start + S + 1, v[8], v[6:0]});
   endtask
   // Model: merge equal consecutive phases into runs; each valid-anode run long enough captures once.
   task automatic run_seq();
      logic [8:0] rv = 9'h000;
      int rs = cyc + 1;
      int rl = 0;
      int t = cyc + 1;
      foreach (seq[i]) begin
         if ({seq[i].an, seq[i].sg} != rv) begin
            finalize(rv, rs, rl);
            rv = {seq[i].an, seq[i].sg};
            rs = t;
            rl = 0;
         end
         rl += seq[i].len;
         t  += seq[i].len;
      end
      finalize(rv, rs, rl);
      foreach (seq[i]) begin
         an = seq[i].an;
         sg = seq[i].sg;
         repeat (seq[i].len) @(posedge clk);
         #1;
      end
      seq.delete();
   endtask
   task automatic add(input logic [1:0] a, input logic [6:0] s, input int len);
      seq.push_back('{a, s, len});
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 200000", cyc);
      $fatal(1);
   end
   initial begin
      logic [4:0] d;
      int c;
      ph_t p;
      logic [8:0] last;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_seg_1", seg_1, 7'h7F);
      check("rst_seg_2", seg_2, 7'h7F);
      check("rst_hex_1", hex_1, 0);
      check("rst_is_hex_2", is_hex_2, 0);
      check("rst_valid_1", valid_1, 0);
      check("rst_valid_2", valid_2, 0);
      check("rst_update", update, 0);
      check("rst_update_sel", update_sel, 0);
      add(2'b00, 7'h00, 1000);
      run_seq();
      check("idle_seg_1", seg_1, 7'h7F);
      check("idle_valid_1", valid_1, 0);
      add(2'b01, 7'h12, 200);
      add(2'b00, 7'h00, 20);
      run_seq();
      d = ref_dec(7'h12);
      check("d1_seg_1", seg_1, 7'h12);
      check("d1_hex_1", hex_1, d[3:0]);
      check("d1_is_hex_1", is_hex_1, d[4]);
      check("d1_valid_1", valid_1, 1);
      check("d1_seg_2", seg_2, 7'h7F);
      check("d1_valid_2", valid_2, 0);
      for (int i = 0; i < 4; i++) begin
         add(2'b01, 7'h4F, 100);
         add(2'b10, 7'h38, 100);
      end
      add(2'b00, 7'h00, 20);
      run_seq();
      d = ref_dec(7'h38);
      check("alt_seg_1", seg_1, 7'h4F);
      check("alt_seg_2", seg_2, 7'h38);
      check("alt_hex_2", hex_2, d[3:0]);
      check("alt_is_hex_2", is_hex_2, d[4]);
      add(2'b01, 7'h06, 60);
      add(2'b00, 7'h00, 30);
      for (int i = 0; i < 5; i++) begin
         add(2'b01, 7'h24, 50);
         add(2'b01, 7'h25, 1);
      end
      add(2'b00, 7'h00, 20);
      run_seq();
      d = ref_dec(7'h4F);
      check("short_seg_1", seg_1, 7'h4F);
      check("short_hex_1", hex_1, d[3:0]);
      check("short_seg_2", seg_2, 7'h38);
      last = 9'h000;
      for (int i = 0; i < 30; i++) begin
         p.an  = 2'($urandom_range(0, 3));
         p.sg  = $urandom_range(0, 1) ? glyph[$urandom_range(0, 15)] : 7'($urandom);
         p.len = $urandom_range(0, 1) ? $urandom_range(1, 60) : $urandom_range(S + 2, 120);
         if ({p.an, p.sg} == last) p.sg = p.sg ^ 7'h01;
         last = {p.an, p.sg};
         seq.push_back(p);
      end
      add(2'b00, 7'h00, 30);
      run_seq();
      c = cyc + 1 + S + 1;
      add(2'b10, 7'h55, 100);
      add(2'b00, 7'h00, 20);
      run_seq();
      check("nh_seg_2", seg_2, 7'h55);
      check("nh_is_hex_2", is_hex_2, 0);
      check("nh_hex_2", hex_2, 0);
      check("nh_valid_2", valid_2, 1);
      repeat (c + T - 1 - cyc) @(posedge clk);
      #1;
      check("to_pre_valid_2", valid_2, 1);
      check("to_pre_seg_2", seg_2, 7'h55);
      @(posedge clk);
      #1;
      check("to_valid_2", valid_2, 0);
      check("to_seg_2", seg_2, 7'h7F);
      check("to_hex_2", hex_2, 0);
      check("to_is_hex_2", is_hex_2, 0);
      an = 2'b01;
      sg = 7'h12;
      repeat (40) @(posedge clk);
      #1;
      rst = 1'b1;
      c = cyc + 1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_seg_1", seg_1, 7'h7F);
      check("mid_rst_valid_1", valid_1, 0);
      check("mid_rst_hex_1", hex_1, 0);
      check("mid_rst_update", update, 0);
      check("mid_rst_update_sel", update_sel, 0);
      sbq.push_back('{c + S + 2, 1'b0, 7'h12});
      repeat (100) @(posedge clk);
      #1;
      an = 2'b00;
      sg = 7'h00;
      repeat (20) @(posedge clk);
      #1;
      check("resettle_seg_1", seg_1, 7'h12);
      check("scoreboard_empty", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
